// File: rtl/atm_prompt_tx.sv
// Prompt transmitter: detects ATM controller state/EXIT changes and streams
// CR LF + prompt text (+ BCD balance digits) over a valid/ready byte interface.
module atm_prompt_tx #(
   parameter int DIGITS  = 4,
   parameter int MAX_LEN = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           current_state,
   input  logic [3:0]            status_code,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  tx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   output logic                  busy
);

   localparam int TW = 8 * MAX_LEN;
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [3:0] EXIT_CODE   = 4'b0111;
   localparam logic [4:0] ID_SHOW_BAL = 5'd4;
   localparam logic [4:0] ID_BYE      = 5'd16;
   localparam logic [4:0] ID_UNK      = 5'd17;

   typedef enum logic [2:0] {S_WAIT, S_CR, S_LF, S_TEXT, S_DIG} state_t;

   state_t              state_reg;
   logic [15:0]         prev_state_reg;
   logic [3:0]          prev_status_reg;
   logic                st_chg_reg;
   logic                exit_evt_reg;
   logic                pending_reg;
   logic                pending_bye_reg;
   logic [4:0]          msg_id_reg;
   logic [LW-1:0]       idx_reg;
   logic [DW-1:0]       dig_idx_reg;
   logic [4*DIGITS-1:0] value_reg;
   logic [7:0]          tx_data_reg;
   logic                tx_valid_reg;
   logic                busy_reg;

   logic [TW-1:0]       text;
   logic [LW-1:0]       len;
   logic [7:0]          dig_ascii [DIGITS];

   // Message id is the one-hot bit position; anything not one-hot gets "?".
   function automatic logic [4:0] msg_of(input logic [15:0] s);
      logic [4:0] id;
      id = ID_UNK;
      if ($onehot(s)) begin
         for (int k = 0; k < 16; k++) begin
            if (s[k]) id = 5'(k);
         end
      end
      return id;
   endfunction

   function automatic logic [7:0] ascii_of(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
   endfunction

   // Text is right-aligned in the ROM word, so byte i sits (len-1-i) bytes up.
   function automatic logic [7:0] char_at(input logic [TW-1:0] t,
                                          input logic [LW-1:0] l,
                                          input logic [LW-1:0] i);
      logic [TW-1:0] s;
      s = '0;
      if (i < l) s = t >> (8 * (l - i - LW'(1)));
      return s[7:0];
   endfunction

   always_comb begin
      text = TW'("?");
      len  = LW'(1);
      case (msg_id_reg)
         5'd0:  begin text = TW'("ATM");       len = LW'(3); end
         5'd1:  begin text = TW'("ACCT:");     len = LW'(5); end
         5'd2:  begin text = TW'("PIN:");      len = LW'(4); end
         5'd3:  begin text = TW'("B C W T:");  len = LW'(8); end
         5'd4:  begin text = TW'("BAL ");      len = LW'(4); end
         5'd5:  begin text = TW'("CONV");      len = LW'(4); end
         5'd6:  begin text = TW'("FROM 1-5:"); len = LW'(9); end
         5'd7:  begin text = TW'("TO 1-5:");   len = LW'(7); end
         5'd8:  begin text = TW'("WDRW");      len = LW'(4); end
         5'd9:  begin text = TW'("AMT:");      len = LW'(4); end
         5'd10: begin text = TW'("XFER");      len = LW'(4); end
         5'd11: begin text = TW'("CUR 1-5:");  len = LW'(8); end
         5'd12: begin text = TW'("AMT:");      len = LW'(4); end
         5'd13: begin text = TW'("ERR");       len = LW'(3); end
         5'd14: begin text = TW'("OK");        len = LW'(2); end
         5'd16: begin text = TW'("BYE");       len = LW'(3); end
         default: begin text = TW'("?");       len = LW'(1); end
      endcase
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
         assign dig_ascii[gi] = ascii_of(value_reg[4*(DIGITS-1-gi) +: 4]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_WAIT;
         prev_state_reg  <= 16'h0000;
         prev_status_reg <= 4'h0;
         st_chg_reg      <= 1'b0;
         exit_evt_reg    <= 1'b0;
         pending_reg     <= 1'b0;
         pending_bye_reg <= 1'b0;
         msg_id_reg      <= ID_UNK;
         idx_reg         <= '0;
         dig_idx_reg     <= '0;
         value_reg       <= '0;
         tx_data_reg     <= 8'h00;
         tx_valid_reg    <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         prev_state_reg  <= current_state;
         prev_status_reg <= status_code;
         st_chg_reg      <= (current_state != prev_state_reg);
         exit_evt_reg    <= (status_code == EXIT_CODE) && (prev_status_reg != EXIT_CODE);

         // Events during a message are deferred; only the latest screen is sent.
         if (state_reg != S_WAIT) begin
            if (st_chg_reg || exit_evt_reg) pending_reg <= 1'b1;
            if (exit_evt_reg) pending_bye_reg <= 1'b1;
         end

         case (state_reg)
            S_WAIT: begin
               if (exit_evt_reg || st_chg_reg || pending_reg) begin
                  msg_id_reg      <= (exit_evt_reg || pending_bye_reg) ? ID_BYE
                                                                       : msg_of(prev_state_reg);
                  pending_reg     <= 1'b0;
                  pending_bye_reg <= 1'b0;
                  tx_data_reg     <= 8'h0D;
                  tx_valid_reg    <= 1'b1;
                  busy_reg        <= 1'b1;
                  state_reg       <= S_CR;
               end
            end
            S_CR: begin
               if (tx_ready) begin
                  tx_data_reg <= 8'h0A;
                  state_reg   <= S_LF;
               end
            end
            S_LF: begin
               if (tx_ready) begin
                  idx_reg     <= '0;
                  tx_data_reg <= char_at(text, len, '0);
                  state_reg   <= S_TEXT;
               end
            end
            S_TEXT: begin
               if (tx_ready) begin
                  if (idx_reg == len - LW'(1)) begin
                     if (msg_id_reg == ID_SHOW_BAL) begin
                        value_reg   <= value;
                        dig_idx_reg <= '0;
                        tx_data_reg <= ascii_of(value[4*DIGITS-1 -: 4]);
                        state_reg   <= S_DIG;
                     end else begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= S_WAIT;
                     end
                  end else begin
                     idx_reg     <= idx_reg + LW'(1);
                     tx_data_reg <= char_at(text, len, idx_reg + LW'(1));
                  end
               end
            end
            S_DIG: begin
               if (tx_ready) begin
                  if (dig_idx_reg == DW'(DIGITS - 1)) begin
                     tx_valid_reg <= 1'b0;
                     busy_reg     <= 1'b0;
                     state_reg    <= S_WAIT;
                  end else begin
                     dig_idx_reg <= dig_idx_reg + DW'(1);
                     tx_data_reg <= dig_ascii[dig_idx_reg + DW'(1)];
                  end
               end
            end
            default: state_reg <= S_WAIT;
         endcase
      end
   end

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_atm_prompt_tx.sv
// Directed bench for atm_prompt_tx: collects transferred bytes and compares
// them with hand-written ASCII sequences.
module tb_atm_prompt_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] current_state = 16'h0000;
   logic [3:0]  status_code = 4'h0;
   logic [15:0] value = 16'h0000;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int found;
   logic [7:0] got_q[$];
   int         stamp_q[$];
   logic [7:0] exp_q[$];

   atm_prompt_tx #(.DIGITS(4), .MAX_LEN(9)) dut (
      .clk(clk), .rst(rst), .current_state(current_state),
      .status_code(status_code), .value(value), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs only change just after posedge, so the negedge view is what the next edge sees.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         got_q.push_back(tx_data);
         stamp_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_msg(input string tag);
      int n;
      $display("msg %s: %0d bytes received, %0d expected", tag, got_q.size(), exp_q.size());
      check({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_rx();
      got_q.delete();
      stamp_q.delete();
   endtask

   initial begin
      // Reset state
      current_state = 16'h0002;
      step(3);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);

      // 1: ACCT re-announced after reset, one byte per cycle
      clear_rx();
      rst = 1'b0;
      step(15);
      exp_q = '{8'h0D, 8'h0A, 8'h41, 8'h43, 8'h43, 8'h54, 8'h3A};
      check_msg("acct");
      check("acct_busy_after", {31'h0, busy}, 32'h0);
      if (stamp_q.size() > 0)
         check("acct_back_to_back", stamp_q[stamp_q.size()-1] - stamp_q[0], stamp_q.size() - 1);

      // 2: balance screen with digits, then invalid nibble
      clear_rx();
      value = 16'h1234;
      current_state = 16'h0010;
      step(20);
      exp_q = '{8'h0D, 8'h0A, 8'h42, 8'h41, 8'h4C, 8'h20, 8'h31, 8'h32, 8'h33, 8'h34};
      check_msg("bal_1234");
      clear_rx();
      current_state = 16'h0001;
      step(12);
      exp_q = '{8'h0D, 8'h0A, 8'h41, 8'h54, 8'h4D};
      check_msg("idle_atm");
      clear_rx();
      value = 16'h12A4;
      current_state = 16'h0010;
      step(20);
      exp_q = '{8'h0D, 8'h0A, 8'h42, 8'h41, 8'h4C, 8'h20, 8'h31, 8'h32, 8'h3F, 8'h34};
      check_msg("bal_12a4");

      // 3: stall on 'P' during PIN prompt
      clear_rx();
      current_state = 16'h0004;
      found = 0;
      for (int k = 0; k < 12 && found == 0; k++) begin
         step(1);
         if (tx_valid && tx_data == 8'h50) found = 1;
      end
      check("pin_p_seen", found, 1);
      tx_ready = 1'b0;
      step(1);
      check("pin_hold1_data", {24'h0, tx_data}, 32'h50);
      check("pin_hold1_valid", {31'h0, tx_valid}, 32'h1);
      step(1);
      check("pin_hold2_data", {24'h0, tx_data}, 32'h50);
      check("pin_hold2_valid", {31'h0, tx_valid}, 32'h1);
      tx_ready = 1'b1;
      step(10);
      exp_q = '{8'h0D, 8'h0A, 8'h50, 8'h49, 8'h4E, 8'h3A};
      check_msg("pin_stall");

      // 4: changes during MENU collapse into a single ERR message
      clear_rx();
      current_state = 16'h0008;
      step(4);
      check("menu_busy_mid", {31'h0, busy}, 32'h1);
      current_state = 16'h0100;
      step(2);
      current_state = 16'h2000;
      step(30);
      exp_q = '{8'h0D, 8'h0A, 8'h42, 8'h20, 8'h43, 8'h20, 8'h57, 8'h20, 8'h54, 8'h3A,
                8'h0D, 8'h0A, 8'h45, 8'h52, 8'h52};
      check_msg("menu_then_err");

      // 5: EXIT edge while idle, latency check, then no retransmit while held
      clear_rx();
      status_code = 4'b0111;
      step(1);
      check("bye_lat_n_valid", {31'h0, tx_valid}, 32'h0);
      step(1);
      check("bye_lat_n1_valid", {31'h0, tx_valid}, 32'h1);
      check("bye_lat_n1_data", {24'h0, tx_data}, 32'h0D);
      step(10);
      exp_q = '{8'h0D, 8'h0A, 8'h42, 8'h59, 8'h45};
      check_msg("bye");
      clear_rx();
      step(20);
      check("bye_hold_quiet", got_q.size(), 0);
      status_code = 4'h0;
      step(3);

      // 6: reset mid-ACCT, full restart, then non-one-hot state
      clear_rx();
      current_state = 16'h0002;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         step(1);
         if (got_q.size() >= 3) found = 1;
      end
      check("acct_3_bytes_seen", found, 1);
      rst = 1'b1;
      tx_ready = 1'b0;
      step(1);
      check("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      clear_rx();
      rst = 1'b0;
      tx_ready = 1'b1;
      step(15);
      exp_q = '{8'h0D, 8'h0A, 8'h41, 8'h43, 8'h43, 8'h54, 8'h3A};
      check_msg("acct_restart");
      clear_rx();
      current_state = 16'h0003;
      step(10);
      exp_q = '{8'h0D, 8'h0A, 8'h3F};
      check_msg("not_onehot");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
